app_input_loader: RTL
=====================

# app_input_loader

Synthesizable input sequencer for `LDPC_Dec`. It streams one code block of initial APP messages from the eight `APPmsg_input_buffer_0` ROM/RAM instances into the decoder. It generates the shared buffer read address, `buffer_valid`/`buffer_start`/`buffer_last` and the `APPmsg_ini_sub_x` sub-block index. Frames are issued back-to-back whenever the decoder reports `buffer_ready`, until `BlkNumperDecoder` blocks have been decoded. The block replaces the bench-side stimulus logic in the top-level integration.

## Interface
Parameters:
- `SHORT_LEN`, default 16: beats in each of sub-blocks 0..2.
- `LONG_LEN`, default 128: beats in sub-block 3.
- `ADDR_LEAD`, default 4: buffer address advances when the in-sub-block beat index equals `len-ADDR_LEAD`.
- `ADDR_W`, default 2: buffer address width.
- `BLK_NUM`, default `` `BlkNumperDecoder ``: blocks per run.
- `CNT_W`, default 3: width of `decode_valid_cnt`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ready`  in  1  run enable from the host; level-sensitive.
- `buffer_ready`  in  1  decoder can accept a new frame.
- `decode_valid`  in  1  decoder output-valid strobe.
- `decode_valid_cnt`  in  `CNT_W`  index of the block being output.
- `buffer_addr`  out  `ADDR_W`  read address, fanned out to all eight buffers.
- `buffer_valid`  out  1  frame beat valid, to `LDPC_Dec`.
- `buffer_start`  out  1  first beat of frame.
- `buffer_last`  out  1  last beat of frame.
- `APPmsg_ini_sub_x`  out  2  current sub-block index.
- `busy`  out  1  frame in flight (ARM or STREAM).
- `end_all`  out  1  sticky: all `BLK_NUM` blocks are decoded.

Every output resets to 0.

## Operation
- Frame length is `FRAME_LEN = 3*SHORT_LEN + LONG_LEN`, which is 176 at the defaults. `beat` runs 0..`FRAME_LEN-1`.
- Sub-block map at the defaults:
  - `APPmsg_ini_sub_x` = 0 for beats 0–15.
  - 1 for beats 16–31.
  - 2 for beats 32–47.
  - 3 for beats 48–175.
- The sub-block index advances on the last beat of each sub-block. It is held at 3 until the frame ends, then returns to 0.
- States:
  - IDLE → ARM when `ready && buffer_ready && !end_all`.
  - ARM lasts 2 cycles to cover buffer read latency, then → STREAM.
  - STREAM lasts `FRAME_LEN` cycles, then → IDLE.
- Frame-start condition is re-evaluated in IDLE only. `ready` and `buffer_ready` are ignored during ARM and STREAM; there is no mid-frame backpressure.
- `buffer_addr`:
  - Is 0 in IDLE.
  - During STREAM it increments by 1, mod 2^`ADDR_W`, on each beat where the sub-block-local index equals `len-ADDR_LEAD`. At the defaults these are local indices 12 and 124.
  - Wraps 3 → 0 silently.
- `end_all`:
  - Set the cycle after `decode_valid && decode_valid_cnt == BLK_NUM-1`.
  - Cleared only by reset.
- If `end_all` sets mid-frame, the current frame completes. No further frame starts.
- Reset mid-frame: all outputs go to 0 immediately and the FSM returns to IDLE. No partial `buffer_last` is produced.

## Timing
- Latency from IDLE accept to the first `buffer_valid` is 3 cycles: the accept edge plus the 2 ARM cycles.
- `buffer_start` is high for exactly one cycle, coincident with beat 0.
- `buffer_last` is high for exactly one cycle, coincident with beat `FRAME_LEN-1`.
- `buffer_valid` is continuous for `FRAME_LEN` cycles with no gaps.
- Back-to-back frames: at least 1 IDLE cycle plus 2 ARM cycles lie between the last beat of one frame and the first beat of the next. `buffer_valid` therefore drops for at least 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Counter widths:
  - The beat counter is `$clog2(FRAME_LEN)` bits.
  - The sub-block-local counter is `$clog2(LONG_LEN)` bits.
  - The local counter resets to 0 at each sub-block boundary.

## Structure
- Shared package `ldpc_dec_pkg`:
  - FSM state enum `{IDLE, ARM, STREAM}`.
  - `FRAME_LEN`.
  - Sub-block length function `sub_len(idx)`.
- Shared include: `Decoder_Parameters.v` supplies `BlkNumperDecoder`.
- Sub-module `subblk_counter`:
  - Holds the local beat counter and the sub-block index.
  - Emits a `wrap` strobe and an `addr_adv` strobe.
- The top level holds the FSM, the frame beat counter, `buffer_addr` and `end_all`.

## Test plan
- Single frame, defaults, `ready`=1, `buffer_ready`=1 from reset release. Required response:
  - `buffer_valid` is high for 176 cycles starting 3 cycles after accept.
  - `buffer_start` is high only on beat 0; `buffer_last` only on beat 175.
  - `APPmsg_ini_sub_x` transitions 0→1→2→3 at beats 16, 32 and 48.
- Address sequence over one frame: increments after beats 12, 28, 44 and 172. Required sequence: 0,1,2,3,0, then 0 in IDLE.
- `buffer_ready` toggled low during beats 50–60. Required: no effect on the stream. Then hold it low after the frame ends. Required: FSM stays in IDLE and `buffer_valid`=0 until `buffer_ready` returns high.
- Pulse `decode_valid` with `decode_valid_cnt`=`BLK_NUM-1` at beat 100 of frame 2. Required:
  - Frame 2 completes all 176 beats.
  - `end_all`=1 from the next cycle.
  - No frame 3 even with `ready`=`buffer_ready`=1.
- Assert `rst_n`=0 at beat 80. Required: all outputs are 0 within the same cycle. After release, a new frame restarts at beat 0 with `buffer_addr`=0.
- `ready`=0 with `buffer_ready`=1. Required: no frame is issued. Raising `ready` starts a frame 3 cycles later.

Source files
------------

// File: rtl/ldpc_dec_pkg.sv
// Shared types and frame geometry for the LDPC decoder input path.
// Blocks-per-run default, used when the integration does not supply one.
`ifndef BlkNumperDecoder
`define BlkNumperDecoder 4
`endif

package ldpc_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int SHORT_LEN_D = 16;
  localparam int LONG_LEN_D  = 128;

  function automatic int frame_len(input int short_len, input int long_len);
    return 3 * short_len + long_len;
  endfunction

  localparam int FRAME_LEN = frame_len(SHORT_LEN_D, LONG_LEN_D);

  // Sub-blocks 0..2 are short, sub-block 3 is the long tail.
  function automatic int sub_len(input logic [1:0] idx, input int short_len, input int long_len);
    return (idx == 2'd3) ? long_len : short_len;
  endfunction

endpackage

// File: rtl/subblk_counter.sv
// Sub-block local beat counter and index; flags the last beat of each
// sub-block (wrap) and the beat where the buffer address should advance.
module subblk_counter
  import ldpc_dec_pkg::*;
#(
  parameter int SHORT_LEN = 16,
  parameter int LONG_LEN  = 128,
  parameter int ADDR_LEAD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] sub_idx,
  output logic       wrap,
  output logic       addr_adv
);

  localparam int LW = $clog2(LONG_LEN);

  logic [LW-1:0] loc;
  logic [LW-1:0] len_m1;
  logic [LW-1:0] lead_pt;

  always_comb begin
    len_m1  = LW'(sub_len(sub_idx, SHORT_LEN, LONG_LEN) - 1);
    lead_pt = LW'(sub_len(sub_idx, SHORT_LEN, LONG_LEN) - ADDR_LEAD);
  end

  assign wrap     = en && (loc == len_m1);
  assign addr_adv = en && (loc == lead_pt);

  // Index wraps 3 -> 0 on the final beat, so it is back at 0 for IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc     <= '0;
      sub_idx <= 2'd0;
    end else if (clr) begin
      loc     <= '0;
      sub_idx <= 2'd0;
    end else if (wrap) begin
      loc     <= '0;
      sub_idx <= sub_idx + 2'd1;
    end else if (en) begin
      loc     <= loc + LW'(1);
    end
  end

endmodule

// File: rtl/app_input_loader.sv
// Streams one code block of initial APP messages per frame into LDPC_Dec:
// FSM (IDLE/ARM/STREAM), frame beat counter, buffer address and end_all.
`ifndef BlkNumperDecoder
`define BlkNumperDecoder 4
`endif

module app_input_loader
  import ldpc_dec_pkg::*;
#(
  parameter int SHORT_LEN = 16,
  parameter int LONG_LEN  = 128,
  parameter int ADDR_LEAD = 4,
  parameter int ADDR_W    = 2,
  parameter int BLK_NUM   = `BlkNumperDecoder,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic              buffer_ready,
  input  logic              decode_valid,
  input  logic [CNT_W-1:0]  decode_valid_cnt,
  output logic [ADDR_W-1:0] buffer_addr,
  output logic              buffer_valid,
  output logic              buffer_start,
  output logic              buffer_last,
  output logic [1:0]        APPmsg_ini_sub_x,
  output logic              busy,
  output logic              end_all
);

  localparam int FLEN = frame_len(SHORT_LEN, LONG_LEN);
  localparam int BW   = $clog2(FLEN);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(FLEN - 1);
  localparam logic [CNT_W-1:0] LAST_BLK  = CNT_W'(BLK_NUM - 1);

  state_e        state, state_nxt;
  logic          arm_cnt;
  logic [BW-1:0] beat;
  logic          streaming;
  logic          sub_wrap;
  logic          addr_adv;
  logic          frame_done;

  assign streaming  = (state == STREAM);
  assign frame_done = sub_wrap && (APPmsg_ini_sub_x == 2'd3);

  subblk_counter #(
    .SHORT_LEN (SHORT_LEN),
    .LONG_LEN  (LONG_LEN),
    .ADDR_LEAD (ADDR_LEAD)
  ) u_subblk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (!streaming),
    .en       (streaming),
    .sub_idx  (APPmsg_ini_sub_x),
    .wrap     (sub_wrap),
    .addr_adv (addr_adv)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (ready && buffer_ready && !end_all) state_nxt = ARM;
      ARM:     if (arm_cnt) state_nxt = STREAM;
      STREAM:  if (frame_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      arm_cnt <= 1'b0;
      beat    <= '0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= (state == ARM) ? !arm_cnt : 1'b0;
      beat    <= (streaming && !frame_done) ? beat + BW'(1) : '0;
    end
  end

  // Address is cleared on the final beat so IDLE always presents 0,
  // even for geometries where the lead points do not sum to a full wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer_addr <= '0;
    end else if (!streaming || frame_done) begin
      buffer_addr <= '0;
    end else if (addr_adv) begin
      buffer_addr <= buffer_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           end_all <= 1'b0;
    else if (decode_valid && decode_valid_cnt == LAST_BLK) end_all <= 1'b1;
  end

  // Outputs decode only flops; no input reaches an output combinationally.
  assign busy         = (state != IDLE);
  assign buffer_valid = streaming;
  assign buffer_start = streaming && (beat == '0);
  assign buffer_last  = streaming && (beat == LAST_BEAT);

endmodule
